maxpool2d2x2s2_engine: RTL and testbench
========================================

# maxpool2d2x2s2_engine

Streaming 2x2, stride-2 max-pooling datapath for the maxpool2d2x2s2 stage. It accepts one feature-map pixel per cycle in raster order and emits one pooled pixel for every 2x2 window. Internal column and row phase counters drive a pairwise-max register and a half-width line buffer, and the output is a valid/ready stream for the next layer. The engine handles a single channel; multi-channel maps are handled by instantiating one engine per channel.

## Interface
Parameters:
- DATA_WIDTH, 16, pixel width in bits, two's-complement signed.
- IMG_WIDTH, 28, input columns. Must be even and ≥ 2.
- IMG_HEIGHT, 28, input rows. Must be even and ≥ 2.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  reset, asynchronous, active-low.
- In_Valid  input  1  In_Data holds a valid pixel.
- In_Ready  output  1  engine can accept a pixel this cycle.
- In_Data  input  DATA_WIDTH  input pixel, raster order (column fastest).
- Out_Valid  output  1  Out_Data holds a pooled pixel.
- Out_Ready  input  1  downstream accepts Out_Data this cycle.
- Out_Data  output  DATA_WIDTH  pooled pixel (signed max of a 2x2 window).
- Out_Last  output  1  qualifies the last pooled pixel of a frame; meaningful only while Out_Valid is high.

## Operation
- Accept: an input pixel is accepted when In_Valid and In_Ready are both high. A pixel is accepted only by this handshake.
- Counters:
  - col (0..IMG_WIDTH-1) advances on every accepted pixel.
  - row (0..IMG_HEIGHT-1) advances when col wraps from IMG_WIDTH-1 to 0.
  - Both counters wrap to 0 after pixel (IMG_WIDTH-1, IMG_HEIGHT-1), so back-to-back frames need no gap.
- Even col: the pixel is stored in the hold register.
- Odd col: hmax = signed max(hold, In_Data).
  - Even row: hmax is written to line_buf[col>>1]. Depth is IMG_WIDTH/2 and the buffer is plain registers or inferred RAM with no reset.
  - Odd row: Out_Data <= signed max(line_buf[col>>1], hmax) and Out_Valid <= 1. Out_Last <= 1 if row == IMG_HEIGHT-1 and col == IMG_WIDTH-1, otherwise 0.
- Compare rules:
  - Signed comparison over the full DATA_WIDTH bits; there is no widening and no overflow.
  - Ties return the equal value.
- Output register: single entry.
  - It clears (Out_Valid <= 0) when Out_Ready is high and no new result is loaded in the same cycle.
  - A simultaneous drain and load keeps Out_Valid at 1 with the new data.
- Backpressure: In_Ready = ~(Out_Valid & ~Out_Ready), combinational.
  - This stalls input whenever the output register is full and not draining.
  - It also stalls pixels that would not produce an output, which keeps the logic simple.
- Reset values (Rst low):
  - col = 0, row = 0, hold = 0.
  - Out_Valid = 0, Out_Data = 0, Out_Last = 0.
  - In_Ready therefore reads 1.
  - line_buf is not reset. Its contents are don't-care because every entry is written on an even row before it is read.
- Reset mid-frame: the partial frame is discarded. After Rst deasserts, the first accepted pixel is treated as (0,0).

## Timing
- Latency: Out_Valid rises on the clock edge that accepts the odd-row, odd-col pixel, so results are visible the cycle after acceptance.
- Throughput: at most one pooled pixel per 4 accepted pixels. The input runs at full rate when Out_Ready is held high.
- Out_Data and Out_Last are stable while Out_Valid=1 and Out_Ready=0.
- Output order: pooled pixels emerge in raster order of the output map (IMG_WIDTH/2 x IMG_HEIGHT/2).
- Pixels with In_Valid low, or offered while In_Ready is low, change no state.

## Test plan
- 4x4 frame, In_Data = 0..15 raster, Out_Ready=1, In_Valid=1 continuous:
  - Outputs are 5, 7, 13, 15, each one cycle after input indices 5, 7, 13, 15.
  - Out_Last is 1 only with 15.
- Signed data, 4x4 frame of all -3, with the single value -1 at (1,2):
  - Outputs are -3, -1, -3, -3.
  - A value 0x7FFF beats 0x8000.
- Backpressure on the 4x4 ramp, Out_Ready=0 after the first result:
  - In_Ready drops while Out_Valid=1.
  - Out_Data holds 5 until Out_Ready=1, then the stream resumes with no loss or duplication.
- Two consecutive 4x4 frames, the second holding ramp values +100:
  - Outputs are 5, 7, 13, 15, 105, 107, 113, 115.
  - Out_Last is 1 on 15 and on 115.
- Reset mid-frame: assert Rst after 6 pixels, then send a full 4x4 ramp.
  - All outputs read 0 during reset.
  - After reset the outputs are exactly 5, 7, 13, 15.
- IMG_WIDTH=2, IMG_HEIGHT=2, pixels 9, -4, 2, 11:
  - One output of 11, with Out_Last=1.

Source files
------------

// File: rtl/maxpool2d2x2s2_engine.sv
// maxpool2d2x2s2_engine: streaming 2x2 stride-2 signed max pooling with a single-entry valid/ready output
module maxpool2d2x2s2_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic                  Out_Last
);
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam int LD = IMG_WIDTH / 2;
  localparam int LW = LD > 1 ? $clog2(LD) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] lb_idx;
  logic signed [DATA_WIDTH-1:0] hold, hmax, vmax;
  logic signed [DATA_WIDTH-1:0] line_buf [LD];
  logic accept, col_last, row_last;
  always_comb begin
    In_Ready = ~(Out_Valid & ~Out_Ready);
    accept   = In_Valid & In_Ready;
    col_last = col == CW'(IMG_WIDTH - 1);
    row_last = row == RW'(IMG_HEIGHT - 1);
    lb_idx   = LW'(col >> 1);
    hmax     = hold > $signed(In_Data) ? hold : $signed(In_Data);
    vmax     = line_buf[lb_idx] > hmax ? line_buf[lb_idx] : hmax;
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Last  <= 1'b0;
    end else begin
      if (Out_Ready) Out_Valid <= 1'b0;
      if (accept) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
        if (!col[0]) hold <= In_Data;
        else if (row[0]) begin
          Out_Valid <= 1'b1;
          Out_Data  <= vmax;
          Out_Last  <= row_last & col_last;
        end
      end
    end
  // every entry is rewritten on an even row before the odd row reads it, so no reset
  always_ff @(posedge Clk)
    if (accept & col[0] & ~row[0]) line_buf[lb_idx] <= hmax;
endmodule

// File: tb/tb_maxpool2d2x2s2_engine.sv
// tb_maxpool2d2x2s2_engine: directed scoreboard bench for a 4x4 and a 2x2 max-pool engine
module tb_maxpool2d2x2s2_engine;
  logic clk = 1'b0;
  logic rst;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [15:0] a_in_data, a_out_data;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [15:0] b_in_data, b_out_data;
  int checks = 0;
  int errors = 0;
  logic [16:0] q[$];
  typedef logic signed [15:0] frame_t [16];
  frame_t fr, fr2;
  logic signed [15:0] bpx [4] = '{16'sd9, -16'sd4, 16'sd2, 16'sd11};

  always #5 clk = ~clk;

  maxpool2d2x2s2_engine #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .Clk(clk), .Rst(rst), .In_Valid(a_in_valid), .In_Ready(a_in_ready), .In_Data(a_in_data),
    .Out_Valid(a_out_valid), .Out_Ready(a_out_ready), .Out_Data(a_out_data), .Out_Last(a_out_last));

  maxpool2d2x2s2_engine #(.DATA_WIDTH(16), .IMG_WIDTH(2), .IMG_HEIGHT(2)) dut_b (
    .Clk(clk), .Rst(rst), .In_Valid(b_in_valid), .In_Ready(b_in_ready), .In_Data(b_in_data),
    .Out_Valid(b_out_valid), .Out_Ready(b_out_ready), .Out_Data(b_out_data), .Out_Last(b_out_last));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] smax(input logic signed [15:0] x, input logic signed [15:0] y);
    return x > y ? x : y;
  endfunction

  always @(negedge clk)
    if (rst && a_out_valid && a_out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 32'(a_out_data), 32'hdead);
      else begin
        logic [16:0] e;
        e = q.pop_front();
        chk("out_data", 32'(a_out_data), 32'(e[15:0]));
        chk("out_last", 32'(a_out_last), 32'(e[16]));
      end
    end

  task automatic push_px(input logic signed [15:0] d);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_data = d;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("in_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t f, input int stall_at);
    logic signed [15:0] ev;
    bit is_out;
    for (int i = 0; i < 16; i++) begin
      push_px(f[i]);
      is_out = (i / 4) % 2 == 1 && (i % 4) % 2 == 1;
      if (is_out) begin
        ev = smax(smax(f[i], f[i-1]), smax(f[i-4], f[i-5]));
        q.push_back({i == 15, ev});
      end
      chk("latency_valid", 32'(a_out_valid), 32'(is_out));
      if (i == stall_at) begin
        a_out_ready = 1'b0;
        a_in_data = f[i+1];
        repeat (4) begin
          @(negedge clk);
          chk("stall_valid", 32'(a_out_valid), 32'd1);
          chk("stall_data", 32'(a_out_data), 32'(ev));
          chk("stall_last", 32'(a_out_last), 32'd0);
          chk("stall_in_ready", 32'(a_in_ready), 32'd0);
        end
        @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    a_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_last", 32'(a_out_last), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // ramp 0..15: expect 5, 7, 13, 15
    for (int i = 0; i < 16; i++) fr[i] = 16'(i);
    send_frame(fr, -1);
    idle(3);
    // all -3 with -1 at row 1 col 2
    for (int i = 0; i < 16; i++) fr2[i] = -16'sd3;
    fr2[6] = -16'sd1;
    send_frame(fr2, -1);
    idle(3);
    // most positive beats most negative
    for (int i = 0; i < 16; i++) fr2[i] = 16'sh8000;
    fr2[0] = 16'sh7fff;
    send_frame(fr2, -1);
    idle(3);
    // backpressure after the first result
    send_frame(fr, 5);
    idle(3);
    // two frames back to back
    for (int i = 0; i < 16; i++) fr2[i] = 16'(i + 100);
    send_frame(fr, -1);
    send_frame(fr2, -1);
    idle(3);
    // reset mid-frame after 6 pixels
    for (int i = 0; i < 6; i++) push_px(16'(i));
    q.push_back({1'b0, 16'd5});
    idle(1);
    rst = 1'b0;
    a_in_valid = 1'b1;
    #2;
    chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
    chk("midrst_out_data", 32'(a_out_data), 32'd0);
    chk("midrst_out_last", 32'(a_out_last), 32'd0);
    chk("midrst_in_ready", 32'(a_in_ready), 32'd1);
    a_in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    send_frame(fr, -1);
    idle(3);
    // 2x2 engine: single window
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data = bpx[i];
      @(posedge clk);
      #1;
      chk("b_out_valid", 32'(b_out_valid), 32'(i == 3));
    end
    b_in_valid = 1'b0;
    chk("b_out_data", 32'(b_out_data), 32'd11);
    chk("b_out_last", 32'(b_out_last), 32'd1);
    @(posedge clk);
    #1;
    chk("b_drained", 32'(b_out_valid), 32'd0);
    idle(2);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
